// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access stage of the 16-bit pipelined CPU.
//   - mem_state_e : sequencing states of the MEM stage FSM
//   - DEF_DATA_W  : default data/address width
//   - DEF_REG_W   : default destination register index width
//   - BYTE_MASK   : mask applied to readData for byte loads
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 4;

  localparam logic [15:0] BYTE_MASK = 16'h00FF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    R_ACC   = 3'd1,
    W_SETUP = 3'd2,
    W_PULSE = 3'd3,
    W_HOLD  = 3'd4
  } mem_state_e;

endpackage

// File: rtl/mem_stage_unit_wb.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register. When load is high at a rising edge the entry is
// captured and valid pulses for exactly one cycle; otherwise valid (and fault)
// return to 0 while the payload holds its last value.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   load                capture the entry at this edge
//   regWriteIn/destRegIn/dataIn/faultIn   entry payload
//   valid/regWrite/destReg/data/fault     registered entry
// -----------------------------------------------------------------------------
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              regWriteIn,
  input  logic [REG_W-1:0]  destRegIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              faultIn,
  output logic              valid,
  output logic              regWrite,
  output logic [REG_W-1:0]  destReg,
  output logic [DATA_W-1:0] data,
  output logic              fault
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= 1'b0;
      regWrite <= 1'b0;
      destReg  <= '0;
      data     <= '0;
      fault    <= 1'b0;
    end else begin
      valid <= load;
      fault <= load & faultIn;
      if (load) begin
        regWrite <= regWriteIn;
        destReg  <= destRegIn;
        data     <= dataIn;
      end
    end
  end

endmodule

// File: rtl/mem_stage_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_unit
// Memory-access stage sitting directly upstream of dataMemory. Accepts one
// EX/MEM request per handshake, sequences memRead/memWrite so address and data
// are stable around dataMemory's level-sensitive write, and retires each
// instruction into the MEM/WB register.
//
// Handshake: a request is taken at a rising edge when ex_valid=1 and
// mem_stall=0; while mem_stall=1 EX must hold its request unchanged.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ex_*                     EX/MEM request fields
//   mem_stall                EX must hold its request
//   memRead, memWrite, wr_enableBW, address, writeWord, writeByte
//                            registered dataMemory drive
//   readData                 dataMemory read port
//   wb_valid/wb_regWrite/wb_destReg/wb_data   MEM/WB entry
//   mem_fault                out-of-range access pulse (with wb_valid)
//   stateDbg                 current FSM state, for observation
//
// Build option: define MEM_BOUNDS_CHECK_EN to suppress memory strobes for
// addresses >= MEM_DEPTH and flag them on mem_fault; otherwise mem_fault is 0.
// -----------------------------------------------------------------------------
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_W     = DEF_REG_W,
  parameter int READ_WAIT = 1,
  parameter int MEM_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_memRead,
  input  logic              ex_memWrite,
  input  logic              ex_byteOp,
  input  logic [DATA_W-1:0] ex_address,
  input  logic [DATA_W-1:0] ex_storeData,
  input  logic [DATA_W-1:0] ex_aluResult,
  input  logic              ex_regWrite,
  input  logic [REG_W-1:0]  ex_destReg,
  output logic              mem_stall,
  output logic              memRead,
  output logic              memWrite,
  output logic              wr_enableBW,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] writeWord,
  output logic [7:0]        writeByte,
  input  logic [DATA_W-1:0] readData,
  output logic              wb_valid,
  output logic              wb_regWrite,
  output logic [REG_W-1:0]  wb_destReg,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_fault,
  output mem_state_e        stateDbg
);

  mem_state_e state, stateNext;
  logic [2:0] cnt, cntNext;

  // Request fields latched at accept, used while the operation is in flight.
  logic              reqByte;
  logic              reqRegWrite;
  logic [REG_W-1:0]  reqDest;
  logic              reqFault;
  // A non-memory op retires one edge after it is accepted.
  logic              aluPend;
  logic [DATA_W-1:0] aluData;

  logic accept, isStore, isLoad, isMemOp, lastRead, faultNow;
  logic memReadNext, memWriteNext;

  logic              wbLoad, wbRegWrite, wbFault;
  logic [REG_W-1:0]  wbDest;
  logic [DATA_W-1:0] wbData;

  assign stateDbg = state;

  // ---------------------------------------------------------------------------
  // Decode and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    lastRead  = (state == R_ACC) && (cnt == 3'd0);
    mem_stall = ((state == R_ACC) && (cnt != 3'd0)) ||
                (state == W_SETUP) || (state == W_PULSE);
    accept    = ex_valid & ~mem_stall;
    // Both strobes high is treated as a store.
    isStore   = ex_memWrite;
    isLoad    = ex_memRead & ~ex_memWrite;
    isMemOp   = ex_memRead | ex_memWrite;
`ifdef MEM_BOUNDS_CHECK_EN
    faultNow  = isMemOp && (ex_address >= DATA_W'(MEM_DEPTH));
`else
    faultNow  = 1'b0;
`endif

    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE:    stateNext = IDLE;
      R_ACC:   begin
        if (cnt != 3'd0) cntNext = cnt - 3'd1;
        else             stateNext = IDLE;
      end
      W_SETUP: stateNext = W_PULSE;
      W_PULSE: stateNext = W_HOLD;
      W_HOLD:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // accept is only possible in IDLE, last R_ACC cycle or W_HOLD, so a new
    // request simply starts its own sequence at this edge.
    if (accept) begin
      if (isStore) begin
        stateNext = W_SETUP;
      end else if (isLoad) begin
        stateNext = R_ACC;
        cntNext   = 3'(READ_WAIT - 1);
      end else begin
        stateNext = IDLE;
      end
    end

    // memRead is held through all but the last R_ACC cycle; memWrite is set
    // only for the single W_PULSE cycle.
    memReadNext  = ((state == R_ACC) && (cnt != 3'd0)) ? memRead : 1'b0;
    memWriteNext = (state == W_SETUP) & ~reqFault;
    if (accept && isLoad) memReadNext = ~faultNow;
  end

  // ---------------------------------------------------------------------------
  // Retirement into MEM/WB
  // ---------------------------------------------------------------------------
  always_comb begin
    wbLoad     = aluPend | lastRead | (state == W_PULSE);
    wbData     = aluData;
    wbRegWrite = reqRegWrite;
    wbDest     = reqDest;
    wbFault    = 1'b0;
    if (lastRead) begin
      if (reqFault)     wbData = '0;
      else if (reqByte) wbData = readData & DATA_W'(BYTE_MASK);
      else              wbData = readData;
      wbRegWrite = reqRegWrite & ~reqFault;
      wbFault    = reqFault;
    end else if (state == W_PULSE) begin
      wbData     = writeWord;
      wbRegWrite = 1'b0;
      wbFault    = reqFault;
    end
  end

  // ---------------------------------------------------------------------------
  // State and dataMemory drive registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      memRead     <= 1'b0;
      memWrite    <= 1'b0;
      wr_enableBW <= 1'b0;
      address     <= '0;
      writeWord   <= '0;
      writeByte   <= 8'h00;
      reqByte     <= 1'b0;
      reqRegWrite <= 1'b0;
      reqDest     <= '0;
      reqFault    <= 1'b0;
      aluPend     <= 1'b0;
      aluData     <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      memRead  <= memReadNext;
      memWrite <= memWriteNext;
      aluPend  <= accept & ~isMemOp;
      if (accept) begin
        reqByte     <= ex_byteOp;
        reqRegWrite <= ex_regWrite;
        reqDest     <= ex_destReg;
        reqFault    <= faultNow;
        if (isMemOp) address <= ex_address;
        else         aluData <= ex_aluResult;
        if (isStore) begin
          writeWord   <= ex_storeData;
          writeByte   <= ex_storeData[7:0];
          wr_enableBW <= ~ex_byteOp;
        end
      end
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (wbLoad),
    .regWriteIn (wbRegWrite),
    .destRegIn  (wbDest),
    .dataIn     (wbData),
    .faultIn    (wbFault),
    .valid      (wb_valid),
    .regWrite   (wb_regWrite),
    .destReg    (wb_destReg),
    .data       (wb_data),
    .fault      (mem_fault)
  );

endmodule

// File: tb/tb_mem_stage_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_unit
// Directed bench for mem_stage_unit (READ_WAIT=1, MEM_DEPTH=8) with a small
// 8-word dataMemory model (combinational read, write while memWrite is high at
// a rising edge; byte stores write {8'h00, writeByte}). Inputs are driven and
// outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_stage_unit;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_memRead, ex_memWrite, ex_byteOp, ex_regWrite;
  logic [15:0] ex_address, ex_storeData, ex_aluResult;
  logic [3:0]  ex_destReg;
  logic        mem_stall, memRead, memWrite, wr_enableBW;
  logic [15:0] address, writeWord, readData, wb_data;
  logic [7:0]  writeByte;
  logic        wb_valid, wb_regWrite, mem_fault;
  logic [3:0]  wb_destReg;
  mem_state_e  stateDbg;

  logic [15:0] mem [0:7];
  logic [15:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_unit #(
    .DATA_W    (16),
    .REG_W     (4),
    .READ_WAIT (1),
    .MEM_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_memRead   (ex_memRead),
    .ex_memWrite  (ex_memWrite),
    .ex_byteOp    (ex_byteOp),
    .ex_address   (ex_address),
    .ex_storeData (ex_storeData),
    .ex_aluResult (ex_aluResult),
    .ex_regWrite  (ex_regWrite),
    .ex_destReg   (ex_destReg),
    .mem_stall    (mem_stall),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .wr_enableBW  (wr_enableBW),
    .address      (address),
    .writeWord    (writeWord),
    .writeByte    (writeByte),
    .readData     (readData),
    .wb_valid     (wb_valid),
    .wb_regWrite  (wb_regWrite),
    .wb_destReg   (wb_destReg),
    .wb_data      (wb_data),
    .mem_fault    (mem_fault),
    .stateDbg     (stateDbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // dataMemory model
  // ---------------------------------------------------------------------------
  assign readData = (memRead && address < 16'd8) ? mem[address[2:0]] : 16'h0000;

  always @(posedge clk) begin
    if (memWrite && address < 16'd8)
      mem[address[2:0]] = wr_enableBW ? writeWord : {8'h00, writeByte};
  end

  // ---------------------------------------------------------------------------
  // Checking and driver tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_wb(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {16'h0, wb_data}, {16'h0, e});
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic bt,
                       input logic [15:0] addr, input logic [15:0] sd,
                       input logic [15:0] alu, input logic rw,
                       input logic [3:0] dst);
    ex_valid     = 1'b1;
    ex_memRead   = rd;
    ex_memWrite  = wr;
    ex_byteOp    = bt;
    ex_address   = addr;
    ex_storeData = sd;
    ex_aluResult = alu;
    ex_regWrite  = rw;
    ex_destReg   = dst;
  endtask

  task automatic release_req();
    ex_valid = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0);
    release_req();
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    mem[0] = 16'h3856;
    mem[6] = 16'hBEDE;

    // Reset state
    step();
    step();
    check("rst_state", 32'(stateDbg), 32'(IDLE));
    check("rst_memWrite", 32'(memWrite), 32'd0);
    check("rst_memRead", 32'(memRead), 32'd0);
    check("rst_wr_enableBW", 32'(wr_enableBW), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_mem_stall", 32'(mem_stall), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    rst = 1'b1;
    step();

    // sw addr 4 data 1234
    drive(1'b0, 1'b1, 1'b0, 16'd4, 16'h1234, 16'h0, 1'b0, 4'h0);
    step();
    release_req();
    check("sw_setup_memWrite", 32'(memWrite), 32'd0);
    check("sw_setup_address", 32'(address), 32'd4);
    check("sw_setup_writeWord", 32'(writeWord), 32'h1234);
    check("sw_setup_wr_enableBW", 32'(wr_enableBW), 32'd1);
    check("sw_setup_stall", 32'(mem_stall), 32'd1);
    step();
    check("sw_pulse_memWrite", 32'(memWrite), 32'd1);
    check("sw_pulse_memRead", 32'(memRead), 32'd0);
    check("sw_pulse_address", 32'(address), 32'd4);
    check("sw_pulse_stall", 32'(mem_stall), 32'd1);
    step();
    check("sw_hold_memWrite", 32'(memWrite), 32'd0);
    check("sw_hold_address", 32'(address), 32'd4);
    check("sw_hold_stall", 32'(mem_stall), 32'd0);
    check("sw_hold_wb_valid", 32'(wb_valid), 32'd1);
    check("sw_hold_wb_regWrite", 32'(wb_regWrite), 32'd0);
    check("sw_mem4", 32'(mem[4]), 32'h1234);
    step();
    check("sw_after_wb_valid", 32'(wb_valid), 32'd0);
    check("sw_after_state", 32'(stateDbg), 32'(IDLE));

    // sb addr 2 data ABCD
    drive(1'b0, 1'b1, 1'b1, 16'd2, 16'hABCD, 16'h0, 1'b0, 4'h0);
    step();
    release_req();
    check("sb_wr_enableBW", 32'(wr_enableBW), 32'd0);
    check("sb_writeByte", 32'(writeByte), 32'hCD);
    step();
    check("sb_pulse_memWrite", 32'(memWrite), 32'd1);
    step();
    check("sb_mem2", 32'(mem[2]), 32'h00CD);
    step();

    // lw addr 0 -> 3856
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'h0, 16'h0, 1'b1, 4'd3);
    exp_q.push_back(16'h3856);
    step();
    release_req();
    check("lw_state", 32'(stateDbg), 32'(R_ACC));
    check("lw_memRead", 32'(memRead), 32'd1);
    check("lw_address", 32'(address), 32'd0);
    check("lw_stall", 32'(mem_stall), 32'd0);
    check("lw_wb_valid_early", 32'(wb_valid), 32'd0);
    step();
    check("lw_wb_valid", 32'(wb_valid), 32'd1);
    check_wb("lw_wb_data");
    check("lw_wb_regWrite", 32'(wb_regWrite), 32'd1);
    check("lw_wb_destReg", 32'(wb_destReg), 32'd3);
    check("lw_memRead_off", 32'(memRead), 32'd0);
    step();
    check("lw_wb_valid_drop", 32'(wb_valid), 32'd0);
    check("lw_wb_data_hold", 32'(wb_data), 32'h3856);

    // lb addr 6 -> 00DE
    drive(1'b1, 1'b0, 1'b1, 16'd6, 16'h0, 16'h0, 1'b1, 4'd4);
    exp_q.push_back(16'h00DE);
    step();
    release_req();
    step();
    check("lb_wb_valid", 32'(wb_valid), 32'd1);
    check_wb("lb_wb_data");
    step();

    // Non-memory op retires one edge after accept
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 16'hBEEF, 1'b0, 4'd9);
    exp_q.push_back(16'hBEEF);
    step();
    release_req();
    check("alu_stall", 32'(mem_stall), 32'd0);
    check("alu_wb_valid_early", 32'(wb_valid), 32'd0);
    step();
    check("alu_wb_valid", 32'(wb_valid), 32'd1);
    check_wb("alu_wb_data");
    check("alu_wb_regWrite", 32'(wb_regWrite), 32'd0);
    check("alu_wb_destReg", 32'(wb_destReg), 32'd9);
    step();

    // Read and write both high is a store
    drive(1'b1, 1'b1, 1'b0, 16'd5, 16'h0F0F, 16'h0, 1'b1, 4'd1);
    step();
    release_req();
    check("rw_state", 32'(stateDbg), 32'(W_SETUP));
    check("rw_memRead", 32'(memRead), 32'd0);
    step();
    check("rw_memWrite", 32'(memWrite), 32'd1);
    check("rw_memRead_pulse", 32'(memRead), 32'd0);
    step();
    check("rw_mem5", 32'(mem[5]), 32'h0F0F);
    step();

    // Back-to-back: sw addr 1, lw addr 1, add
    drive(1'b0, 1'b1, 1'b0, 16'd1, 16'h5A5A, 16'h0, 1'b0, 4'h0);
    step();
    release_req();
    step();
    step();
    check("b2b_hold_state", 32'(stateDbg), 32'(W_HOLD));
    check("b2b_hold_stall", 32'(mem_stall), 32'd0);
    check("b2b_mem1", 32'(mem[1]), 32'h5A5A);
    drive(1'b1, 1'b0, 1'b0, 16'd1, 16'h0, 16'h0, 1'b1, 4'd5);
    exp_q.push_back(16'h5A5A);
    step();
    check("b2b_lw_state", 32'(stateDbg), 32'(R_ACC));
    check("b2b_lw_memRead", 32'(memRead), 32'd1);
    check("b2b_lw_memWrite", 32'(memWrite), 32'd0);
    check("b2b_lw_address", 32'(address), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 16'h0007, 1'b1, 4'd6);
    exp_q.push_back(16'h0007);
    step();
    release_req();
    check("b2b_lw_wb_valid", 32'(wb_valid), 32'd1);
    check_wb("b2b_lw_wb_data");
    check("b2b_lw_wb_destReg", 32'(wb_destReg), 32'd5);
    step();
    check("b2b_add_wb_valid", 32'(wb_valid), 32'd1);
    check_wb("b2b_add_wb_data");
    check("b2b_add_wb_destReg", 32'(wb_destReg), 32'd6);
    check("b2b_add_wb_regWrite", 32'(wb_regWrite), 32'd1);
    step();
    check("b2b_wb_valid_drop", 32'(wb_valid), 32'd0);

    // Reset during W_PULSE
    drive(1'b0, 1'b1, 1'b0, 16'd3, 16'h1111, 16'h0, 1'b0, 4'h0);
    step();
    release_req();
    step();
    check("rstw_pulse_memWrite", 32'(memWrite), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstw_memWrite", 32'(memWrite), 32'd0);
    check("rstw_state", 32'(stateDbg), 32'(IDLE));
    check("rstw_wb_valid", 32'(wb_valid), 32'd0);
    check("rstw_wr_enableBW", 32'(wr_enableBW), 32'd0);
    step();
    check("rstw_mem3", 32'(mem[3]), 32'h0000);
    rst = 1'b1;
    step();

    // Out-of-range load and store
    drive(1'b1, 1'b0, 1'b0, 16'h0009, 16'h0, 16'h0, 1'b1, 4'd2);
    step();
    release_req();
`ifdef MEM_BOUNDS_CHECK_EN
    check("oob_lw_memRead", 32'(memRead), 32'd0);
    check("oob_lw_state", 32'(stateDbg), 32'(R_ACC));
    step();
    check("oob_lw_wb_valid", 32'(wb_valid), 32'd1);
    check("oob_lw_mem_fault", 32'(mem_fault), 32'd1);
    check("oob_lw_wb_data", 32'(wb_data), 32'd0);
    check("oob_lw_wb_regWrite", 32'(wb_regWrite), 32'd0);
    step();
    check("oob_lw_fault_drop", 32'(mem_fault), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 16'h000A, 16'h2222, 16'h0, 1'b0, 4'h0);
    step();
    release_req();
    step();
    check("oob_sw_memWrite", 32'(memWrite), 32'd0);
    step();
    check("oob_sw_wb_valid", 32'(wb_valid), 32'd1);
    check("oob_sw_mem_fault", 32'(mem_fault), 32'd1);
    step();
`else
    check("oob_lw_memRead", 32'(memRead), 32'd1);
    step();
    check("oob_lw_wb_valid", 32'(wb_valid), 32'd1);
    check("oob_lw_mem_fault", 32'(mem_fault), 32'd0);
    check("oob_lw_wb_regWrite", 32'(wb_regWrite), 32'd1);
    step();
`endif

    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
